// File: rtl/mic1_step_ctrl.sv
// MIC1 single-step strobe generator: synchronised, debounced pushbutton stepping.
// Define MIC1_STEP_AUTORUN_EN to add the run switch and a free-running RUN mode.

module mic1_step_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic i_raw,
    output logic o_stable
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_stable;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync   <= 2'b00;
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_raw};
            if (r_sync[1] == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == LAST) begin
                r_stable <= r_sync[1];
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_stable = r_stable;
endmodule

module mic1_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16,
    parameter int RUN_PERIOD      = 1000000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             btn_raw,
    input  logic             run_sw,
    input  logic             halt,
    output logic             step,
    output logic [CNT_W-1:0] step_count,
    output logic             btn_stable,
    output logic             running
);
`ifdef MIC1_STEP_AUTORUN_EN
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_REL = 2'd1,
        S_RUN      = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_REL = 2'd1
    } state_t;
`endif

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_step;
    logic             w_step_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_btn_prev;
    logic             w_btn_stable;
    logic             w_btn_rise;

    mic1_step_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_btn (
        .clock   (clock),
        .reset   (reset),
        .i_raw   (btn_raw),
        .o_stable(w_btn_stable)
    );

    assign w_btn_rise = w_btn_stable & ~r_btn_prev;

`ifdef MIC1_STEP_AUTORUN_EN
    localparam int DIV_W = $clog2(RUN_PERIOD);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_PERIOD - 1);

    logic             w_run_stable;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_nxt;

    mic1_step_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_run (
        .clock   (clock),
        .reset   (reset),
        .i_raw   (run_sw),
        .o_stable(w_run_stable)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_div <= '0;
        end else begin
            r_div <= w_div_nxt;
        end
    end

    assign running = (r_state == S_RUN);
`else
    logic w_unused;
    assign w_unused = run_sw | (RUN_PERIOD == 0);
    assign running  = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_step     <= 1'b0;
            r_cnt      <= '0;
            r_btn_prev <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_step     <= w_step_nxt;
            r_btn_prev <= w_btn_stable;
            if (r_step) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = 1'b0;
`ifdef MIC1_STEP_AUTORUN_EN
        w_div_nxt   = r_div;
`endif
        unique case (r_state)
            S_IDLE: begin
`ifdef MIC1_STEP_AUTORUN_EN
                if (w_run_stable) begin
                    w_state_nxt = S_RUN;
                end else
`endif
                // a press under halt is still consumed
                if (w_btn_rise) begin
                    w_state_nxt = S_WAIT_REL;
                    w_step_nxt  = ~halt;
                end
            end
            S_WAIT_REL: begin
                if (!w_btn_stable) begin
                    w_state_nxt = S_IDLE;
                end
            end
`ifdef MIC1_STEP_AUTORUN_EN
            S_RUN: begin
                if (!w_run_stable) begin
                    w_state_nxt = w_btn_stable ? S_WAIT_REL : S_IDLE;
                    w_div_nxt   = '0;
                end else if (!halt) begin
                    if (r_div == DIV_LAST) begin
                        w_step_nxt = 1'b1;
                        w_div_nxt  = '0;
                    end else begin
                        w_div_nxt = r_div + DIV_W'(1);
                    end
                end
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign step       = r_step;
    assign step_count = r_cnt;
    assign btn_stable = w_btn_stable;
endmodule

// File: tb/tb_mic1_step_ctrl.sv
// Scoreboard bench for mic1_step_ctrl: expected steps are queued by the
// stimulus and matched by a monitor sampling on the falling edge.

module tb_mic1_step_ctrl;
    typedef struct {
        int         cyc;
        logic [3:0] cnt;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       btn_raw;
    logic       run_sw;
    logic       halt;
    logic       step;
    logic [3:0] step_count;
    logic       btn_stable;
    logic       running;

    int         cyc;
    int         n_chk;
    int         n_fail;
    logic [3:0] exp_cnt;
    exp_t       q[$];

    mic1_step_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (4),
        .RUN_PERIOD     (8)
    ) dut (
        .clock     (clk),
        .reset     (reset),
        .btn_raw   (btn_raw),
        .run_sw    (run_sw),
        .halt      (halt),
        .step      (step),
        .step_count(step_count),
        .btn_stable(btn_stable),
        .running   (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_step(input int at);
        exp_t e;
        e.cyc = at;
        e.cnt = exp_cnt;
        q.push_back(e);
        exp_cnt = exp_cnt + 4'd1;
    endtask

    task automatic press(input int hold, input bit want);
        btn_raw = 1'b1;
        if (want) push_step(cyc + 7);
        tick(hold);
        btn_raw = 1'b0;
        tick(12);
    endtask

    always @(negedge clk) begin
        if (step) begin
            if (q.size() == 0) begin
                chk("unexpected_step", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("step_edge", cyc, e.cyc);
                chk("step_count_at_step", int'(step_count), int'(e.cnt));
            end
        end
    end

    initial begin
        int e0;
        n_chk   = 0;
        n_fail  = 0;
        exp_cnt = 4'd0;
        reset   = 1'b1;
        btn_raw = 1'b0;
        run_sw  = 1'b0;
        halt    = 1'b0;
        tick(3);
        chk("rst_step", int'(step), 0);
        chk("rst_count", int'(step_count), 0);
        chk("rst_btn_stable", int'(btn_stable), 0);
        chk("rst_running", int'(running), 0);
        reset = 1'b0;
        tick(2);

        // clean press held 20 clocks
        e0 = cyc;
        btn_raw = 1'b1;
        push_step(e0 + 7);
        tick(5);
        chk("clean_stable_e5", int'(btn_stable), 0);
        tick(1);
        chk("clean_stable_e6", int'(btn_stable), 1);
        tick(14);
        chk("clean_count", int'(step_count), 1);
        btn_raw = 1'b0;
        tick(12);

        // 3-clock glitch, 2 low, then held
        btn_raw = 1'b1;
        tick(3);
        btn_raw = 1'b0;
        tick(2);
        btn_raw = 1'b1;
        push_step(cyc + 7);
        tick(20);
        btn_raw = 1'b0;
        tick(12);
        chk("bounce_count", int'(step_count), 2);

        // halted press is consumed without a step
        halt = 1'b1;
        press(12, 1'b0);
        chk("halt_count", int'(step_count), 2);
        halt = 1'b0;
        press(12, 1'b1);
        chk("after_halt_count", int'(step_count), 3);

        for (int i = 0; i < 12; i++) press(10, 1'b1);
        chk("count_15", int'(step_count), 15);
        press(10, 1'b1);
        chk("wrap_0", int'(step_count), 0);
        for (int i = 0; i < 15; i++) press(10, 1'b1);
        chk("wrap_15", int'(step_count), 15);

        // reset while the button is held and stable
        btn_raw = 1'b1;
        push_step(cyc + 7);
        tick(10);
        chk("pre_rst_stable", int'(btn_stable), 1);
        reset = 1'b1;
        tick(1);
        chk("midrst_step", int'(step), 0);
        chk("midrst_count", int'(step_count), 0);
        chk("midrst_btn_stable", int'(btn_stable), 0);
        chk("midrst_running", int'(running), 0);
        reset   = 1'b0;
        exp_cnt = 4'd0;
        push_step(cyc + 7);
        tick(12);
        chk("post_rst_count", int'(step_count), 1);
        btn_raw = 1'b0;
        tick(12);

`ifdef MIC1_STEP_AUTORUN_EN
        e0 = cyc;
        run_sw = 1'b1;
        push_step(e0 + 15);
        push_step(e0 + 23);
        push_step(e0 + 36);
        tick(8);
        chk("run_running", int'(running), 1);
        tick(16);
        halt = 1'b1;
        tick(5);
        halt = 1'b0;
        tick(8);
        run_sw = 1'b0;
        tick(20);
        chk("run_stopped", int'(running), 0);
        chk("run_count", int'(step_count), 4);
`else
        run_sw = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (running) chk("noauto_running", int'(running), 0);
        end
        chk("noauto_running_end", int'(running), 0);
        chk("noauto_count", int'(step_count), 1);
        run_sw = 1'b0;
`endif
        tick(5);
        chk("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
